sprite_memory_dp: RTL and testbench
===================================

Name: sprite_memory_dp

Overview:
- Parametrised, dual-port sprite colour store; next generation of the single-port sprite colour memory.
- Separate write port (sprite loader / processor bus) and read port (pixel pipeline). Both run in the same cycle.
- Selectable read latency and selectable read-during-write behaviour.
- Built-in bulk clear engine that fills the array with a constant colour, plus per-access completion and error strobes.
- Sits between the sprite loader and the pixel drawing pipeline.

Parameters:
- DATA_W, 9, colour word width in bits (3R3G3B).
- ADDR_W, 14, address width.
- DEPTH, 16384, number of words; must be ≤ 2^ADDR_W.
- OUT_REG, 1, adds a read output register (0 or 1). Read latency = 1 + OUT_REG.
- RDW_BYPASS, 0, read of the address being written in the same cycle: 0 returns the old word, 1 returns the new word.
- CLEAR_VALUE, 0, word written to every location by the clear engine.

Ports:
- clock, input, 1, single clock; all logic on its rising edge.
- reset_n, input, 1, asynchronous, active-low reset.
- wr_en, input, 1, write request, sampled each cycle.
- wr_addr, input, ADDR_W, write address.
- wr_data, input, DATA_W, write data.
- wr_done, output, 1, one-cycle pulse, cycle after an accepted write.
- wr_err, output, 1, one-cycle pulse, cycle after a rejected write.
- rd_en, input, 1, read request.
- rd_addr, input, ADDR_W, read address.
- rd_data, output, DATA_W, read data; holds its value between reads.
- rd_valid, output, 1, high for one cycle when rd_data carries a new result.
- clear_start, input, 1, request a bulk clear.
- busy, output, 1, high while the clear engine runs.
- clear_done, output, 1, one-cycle pulse when a clear completes.

Behaviour:
- Reset (reset_n low, asynchronous):
  - wr_done, wr_err, rd_valid, busy, clear_done = 0; rd_data = 0; FSM = IDLE; clear counter = 0.
  - Array contents are not reset.
- Memory: inferred array, DEPTH x DATA_W; one write and one read per cycle.
- Write acceptance: wr_en = 1, wr_addr < DEPTH and FSM = IDLE → word written at that edge; wr_done = 1 on the next cycle.
- Write rejection: wr_en = 1 with wr_addr ≥ DEPTH or FSM = CLEAR → no write; wr_err = 1 on the next cycle. wr_done and wr_err are never high together.
- Read:
  - rd_en = 1 at edge N → rd_data updated and rd_valid = 1 at edge N + 1 + OUT_REG. Pipeline fully throughput-capable: back-to-back reads give back-to-back valids.
  - rd_addr ≥ DEPTH → rd_data = 0 with rd_valid = 1.
  - Reads are allowed in every FSM state.
- Read-during-write to the same address, same cycle: behaviour per RDW_BYPASS. This applies to user writes and clear-engine writes alike.
- FSM:
  - IDLE: clear_start = 1 → CLEAR on the next edge; counter = 0; busy = 1 from that edge.
  - CLEAR: each cycle write CLEAR_VALUE at the counter address, then counter + 1. The cycle that writes DEPTH-1 returns to IDLE at the following edge; busy drops and clear_done pulses for one cycle at that edge. A clear occupies exactly DEPTH cycles with busy = 1.
  - clear_start while in CLEAR is ignored.
  - clear_start and wr_en together in IDLE: the write is accepted (it is the last user write), then the clear starts.
- Counter width = ADDR_W; no wrap, since the terminal count is DEPTH-1.
- Reset mid-clear: FSM goes to IDLE immediately; array is partially cleared; no clear_done is issued.
- Reset mid-read: pending rd_valid is cancelled.

Test Plan:
- Reset, then write addr 0x0005 data 0x1A5; next cycle read 0x0005 (OUT_REG=1) → wr_done pulse one cycle after the write; rd_valid and rd_data = 0x1A5 exactly 2 cycles after rd_en.
- Reads every cycle to addresses 0..7 preloaded with 0x100+i → 8 consecutive rd_valid cycles with data 0x100..0x107 in order, latency 2 (latency 1 with OUT_REG=0).
- Same-cycle write 0x0AA and read of addr 0x0010 (old word 0x011) → RDW_BYPASS=0 returns 0x011; RDW_BYPASS=1 returns 0x0AA.
- Write to addr 16384 with DEPTH=16384 → wr_err pulse, no wr_done; a read of 16384 returns 0 with rd_valid.
- clear_start with DEPTH=64, CLEAR_VALUE=0x1FF; issue a write at cycle 10 → busy high for exactly 64 cycles; clear_done pulses once; the write gets wr_err; all 64 addresses then read 0x1FF.
- Assert reset_n low during clear cycle 20 → busy, clear_done and rd_valid drop immediately; no clear_done afterwards; a new clear_start then completes normally.

Source files
------------

// File: rtl/sprite_memory_dp_if.sv
// Bus interface of the dual-port sprite colour store: write port, read port,
// clear-engine control and the FSM debug view.
interface sprite_memory_dp_if #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 14
);
    // Handshake: wr_en, rd_en and clear_start are plain per-cycle requests with
    // no ready back-pressure. The store samples them on every rising edge and
    // always answers. A write gets exactly one of wr_done / wr_err one cycle
    // later. A read gets rd_valid with rd_data 1 + OUT_REG cycles later.
    // clear_start is honoured only when busy is low; busy stays high for the
    // whole clear, and clear_done pulses once at the end.
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_done;
    logic              wr_err;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              clear_start;
    logic              busy;
    logic              clear_done;
    logic              fsm_state;   // debug view of the FSM: 0 = IDLE, 1 = CLEAR

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, clear_start,
        input  wr_done, wr_err, rd_data, rd_valid, busy, clear_done, fsm_state
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clear_start,
        output wr_done, wr_err, rd_data, rd_valid, busy, clear_done, fsm_state
    );
endinterface

// File: rtl/sprite_memory_dp.sv
// Dual-port sprite colour store. It has one write port (sprite loader) and one
// read port (pixel pipeline), both active in the same cycle. A selectable
// output register and read-during-write behaviour are provided. A built-in
// engine fills the whole array with CLEAR_VALUE.
module sprite_memory_dp #(
    parameter int                DATA_W      = 9,
    parameter int                ADDR_W      = 14,
    parameter int                DEPTH       = 16384,
    parameter int                OUT_REG     = 1,
    parameter int                RDW_BYPASS  = 0,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input logic               clock,
    input logic               reset_n,
    sprite_memory_dp_if.slave bus
);
    // The array index only needs enough bits for DEPTH words. Range checks
    // are done against the full address first.
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              busy_q;
    logic              clear_done_q;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              wr_in_range;
    logic              rd_in_range;
    logic              user_wr_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rdw_hit;

    logic              wr_done_q;
    logic              wr_err_q;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              rd_valid_o;
    logic [DATA_W-1:0] rd_data_o;

    // Write-port arbitration: while the clear runs it owns the write port, and user writes are refused.
    always_comb begin
        wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_W);
        rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_W);
        user_wr_ok  = bus.wr_en && wr_in_range && (state == IDLE);
        mem_we      = user_wr_ok || (state == CLEAR);
        mem_waddr   = (state == CLEAR) ? clr_cnt : bus.wr_addr;
        mem_wdata   = (state == CLEAR) ? CLEAR_VALUE : bus.wr_data;
        rdw_hit     = mem_we && (mem_waddr == bus.rd_addr);
    end

    // Storage array: one write per cycle; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
        end
    end

    // First read stage: array read, same-address bypass, and zero for out-of-range addresses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= bus.rd_en;
            if (bus.rd_en) begin
                if (!rd_in_range) begin
                    s1_data <= '0;
                end else if ((RDW_BYPASS != 0) && rdw_hit) begin
                    s1_data <= mem_wdata;
                end else begin
                    s1_data <= mem[bus.rd_addr[IDX_W-1:0]];
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            // Optional output register: adds one cycle and holds data between reads.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    rd_valid_o <= 1'b0;
                    rd_data_o  <= '0;
                end else begin
                    rd_valid_o <= s1_valid;
                    if (s1_valid) begin
                        rd_data_o <= s1_data;
                    end
                end
            end
        end else begin : g_no_out_reg
            // No output register: stage one drives the port directly.
            always_comb begin
                rd_valid_o = s1_valid;
                rd_data_o  = s1_data;
            end
        end
    endgenerate

    // Write completion strobes: exactly one of done/err per requested write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_done_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            wr_done_q <= user_wr_ok;
            wr_err_q  <= bus.wr_en && !user_wr_ok;
        end
    end

    // Clear engine FSM: sweeps addresses 0..DEPTH-1 once, one per cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            clr_cnt      <= '0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            clear_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clear_start) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state        <= IDLE;
                        clr_cnt      <= '0;
                        busy_q       <= 1'b0;
                        clear_done_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_done    = wr_done_q;
    assign bus.wr_err     = wr_err_q;
    assign bus.rd_valid   = rd_valid_o;
    assign bus.rd_data    = rd_data_o;
    assign bus.busy       = busy_q;
    assign bus.clear_done = clear_done_q;
    assign bus.fsm_state  = (state == CLEAR);
endmodule

// File: tb/tb_sprite_memory_dp.sv
// Directed bench for sprite_memory_dp using two configurations side by side.
// u_dut_a: DEPTH 16384, ADDR_W 15, OUT_REG 1, old-data read-during-write.
// u_dut_b: DEPTH 64, OUT_REG 0, new-data bypass, CLEAR_VALUE 0x1FF.
module tb_sprite_memory_dp;
    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    sprite_memory_dp_if #(.DATA_W(9), .ADDR_W(15)) bus_a ();
    sprite_memory_dp_if #(.DATA_W(9), .ADDR_W(14)) bus_b ();

    sprite_memory_dp #(
        .DATA_W(9), .ADDR_W(15), .DEPTH(16384), .OUT_REG(1),
        .RDW_BYPASS(0), .CLEAR_VALUE(9'h000)
    ) u_dut_a (
        .clock(clock), .reset_n(reset_n), .bus(bus_a.slave)
    );

    sprite_memory_dp #(
        .DATA_W(9), .ADDR_W(14), .DEPTH(64), .OUT_REG(0),
        .RDW_BYPASS(1), .CLEAR_VALUE(9'h1FF)
    ) u_dut_b (
        .clock(clock), .reset_n(reset_n), .bus(bus_b.slave)
    );

    // Clock
    always #5 clock = ~clock;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
        bus_a.rd_en = 1'b0; bus_a.rd_addr = '0; bus_a.clear_start = 1'b0;
        bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
        bus_b.rd_en = 1'b0; bus_b.rd_addr = '0; bus_b.clear_start = 1'b0;
    endtask

    task automatic drive_write(input int addr, input logic [8:0] data);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 15'(addr); bus_a.wr_data = data;
        bus_b.wr_en = 1'b1; bus_b.wr_addr = 14'(addr); bus_b.wr_data = data;
    endtask

    task automatic drive_read(input logic en, input int addr);
        bus_a.rd_en = en; bus_a.rd_addr = 15'(addr);
        bus_b.rd_en = en; bus_b.rd_addr = 14'(addr);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        #2;
        checks++; if (bus_a.wr_done !== 1'b0) begin errors++; $display("FAIL reset_wr_done: got %b expected 0", bus_a.wr_done); end
        checks++; if (bus_a.wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got %b expected 0", bus_a.wr_err); end
        checks++; if (bus_a.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid_a: got %b expected 0", bus_a.rd_valid); end
        checks++; if (bus_a.rd_data !== 9'h000) begin errors++; $display("FAIL reset_rd_data_a: got %h expected 000", bus_a.rd_data); end
        checks++; if (bus_b.rd_data !== 9'h000) begin errors++; $display("FAIL reset_rd_data_b: got %h expected 000", bus_b.rd_data); end
        checks++; if (bus_b.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid_b: got %b expected 0", bus_b.rd_valid); end
        checks++; if (bus_b.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_b.busy); end
        checks++; if (bus_b.clear_done !== 1'b0) begin errors++; $display("FAIL reset_clear_done: got %b expected 0", bus_b.clear_done); end
        checks++; if (bus_b.fsm_state !== 1'b0) begin errors++; $display("FAIL reset_fsm_state: got %b expected 0", bus_b.fsm_state); end
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        drive_write(5, 9'h1A5);
        step();
        checks++; if (bus_a.wr_done !== 1'b1) begin errors++; $display("FAIL wr_done_a: got %b expected 1", bus_a.wr_done); end
        checks++; if (bus_a.wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_a: got %b expected 0", bus_a.wr_err); end
        checks++; if (bus_b.wr_done !== 1'b1) begin errors++; $display("FAIL wr_done_b: got %b expected 1", bus_b.wr_done); end
        idle_inputs();
        drive_read(1'b1, 5);
        step();
        checks++; if (bus_a.wr_done !== 1'b0) begin errors++; $display("FAIL wr_done_pulse: got %b expected 0", bus_a.wr_done); end
        checks++; if (bus_a.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_lat2_early: got %b expected 0", bus_a.rd_valid); end
        checks++; if (bus_b.rd_valid !== 1'b1 || bus_b.rd_data !== 9'h1A5) begin errors++; $display("FAIL rd_lat1_b: got v=%b d=%h expected v=1 d=1a5", bus_b.rd_valid, bus_b.rd_data); end
        idle_inputs();
        step();
        checks++; if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 9'h1A5) begin errors++; $display("FAIL rd_lat2_a: got v=%b d=%h expected v=1 d=1a5", bus_a.rd_valid, bus_a.rd_data); end
        checks++; if (bus_b.rd_valid !== 1'b0 || bus_b.rd_data !== 9'h1A5) begin errors++; $display("FAIL rd_hold_b: got v=%b d=%h expected v=0 d=1a5", bus_b.rd_valid, bus_b.rd_data); end
        step();
        checks++; if (bus_a.rd_valid !== 1'b0 || bus_a.rd_data !== 9'h1A5) begin errors++; $display("FAIL rd_hold_a: got v=%b d=%h expected v=0 d=1a5", bus_a.rd_valid, bus_a.rd_data); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_d;
        for (int i = 0; i < 8; i++) begin
            drive_write(i, 9'(9'h100 + i));
            step();
            checks++; if ({bus_a.wr_done, bus_b.wr_done} !== 2'b11) begin errors++; $display("FAIL preload_wr_done[%0d]: got %b expected 11", i, {bus_a.wr_done, bus_b.wr_done}); end
        end
        idle_inputs();
        for (int j = 0; j < 11; j++) begin
            drive_read(j < 8, j);
            step();
            // a shows the read issued one step earlier; b shows this step's read
            exp_d = 9'(9'h100 + j - 1);
            if (j >= 1 && j <= 8) begin
                checks++; if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== exp_d) begin errors++; $display("FAIL burst_a[%0d]: got v=%b d=%h expected v=1 d=%h", j, bus_a.rd_valid, bus_a.rd_data, exp_d); end
            end else begin
                checks++; if (bus_a.rd_valid !== 1'b0) begin errors++; $display("FAIL burst_a_idle[%0d]: got %b expected 0", j, bus_a.rd_valid); end
            end
            exp_d = 9'(9'h100 + j);
            if (j < 8) begin
                checks++; if (bus_b.rd_valid !== 1'b1 || bus_b.rd_data !== exp_d) begin errors++; $display("FAIL burst_b[%0d]: got v=%b d=%h expected v=1 d=%h", j, bus_b.rd_valid, bus_b.rd_data, exp_d); end
            end else begin
                checks++; if (bus_b.rd_valid !== 1'b0) begin errors++; $display("FAIL burst_b_idle[%0d]: got %b expected 0", j, bus_b.rd_valid); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_rdw();
        drive_write(16, 9'h011);
        step();
        drive_write(16, 9'h0AA);
        drive_read(1'b1, 16);
        step();
        checks++; if (bus_b.rd_valid !== 1'b1 || bus_b.rd_data !== 9'h0AA) begin errors++; $display("FAIL rdw_bypass_new: got v=%b d=%h expected v=1 d=0aa", bus_b.rd_valid, bus_b.rd_data); end
        idle_inputs();
        step();
        checks++; if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 9'h011) begin errors++; $display("FAIL rdw_old: got v=%b d=%h expected v=1 d=011", bus_a.rd_valid, bus_a.rd_data); end
        drive_read(1'b1, 16);
        step();
        idle_inputs();
        checks++; if (bus_b.rd_data !== 9'h0AA) begin errors++; $display("FAIL rdw_stored_b: got %h expected 0aa", bus_b.rd_data); end
        step();
        checks++; if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 9'h0AA) begin errors++; $display("FAIL rdw_stored_a: got v=%b d=%h expected v=1 d=0aa", bus_a.rd_valid, bus_a.rd_data); end
    endtask

    task automatic test_out_of_range();
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 15'h4000; bus_a.wr_data = 9'h155;
        bus_b.wr_en = 1'b1; bus_b.wr_addr = 14'd64;   bus_b.wr_data = 9'h155;
        step();
        idle_inputs();
        checks++; if (bus_a.wr_err !== 1'b1 || bus_a.wr_done !== 1'b0) begin errors++; $display("FAIL oor_wr_a: got err=%b done=%b expected err=1 done=0", bus_a.wr_err, bus_a.wr_done); end
        checks++; if (bus_b.wr_err !== 1'b1 || bus_b.wr_done !== 1'b0) begin errors++; $display("FAIL oor_wr_b: got err=%b done=%b expected err=1 done=0", bus_b.wr_err, bus_b.wr_done); end
        bus_a.rd_en = 1'b1; bus_a.rd_addr = 15'h4000;
        bus_b.rd_en = 1'b1; bus_b.rd_addr = 14'd64;
        step();
        checks++; if (bus_a.wr_err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse: got %b expected 0", bus_a.wr_err); end
        checks++; if (bus_b.rd_valid !== 1'b1 || bus_b.rd_data !== 9'h000) begin errors++; $display("FAIL oor_rd_b: got v=%b d=%h expected v=1 d=000", bus_b.rd_valid, bus_b.rd_data); end
        drive_read(1'b1, 0);
        step();
        checks++; if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 9'h000) begin errors++; $display("FAIL oor_rd_a: got v=%b d=%h expected v=1 d=000", bus_a.rd_valid, bus_a.rd_data); end
        checks++; if (bus_b.rd_data !== 9'h100) begin errors++; $display("FAIL oor_no_alias_b: got %h expected 100", bus_b.rd_data); end
        idle_inputs();
        step();
        checks++; if (bus_a.rd_data !== 9'h100) begin errors++; $display("FAIL oor_no_alias_a: got %h expected 100", bus_a.rd_data); end
    endtask

    // Runs one clear on b, starting with clear_start already applied for edge 0.
    task automatic run_clear(input string tag, input logic with_traffic);
        int busy_cnt;
        int done_cnt;
        int done_k;
        step();
        bus_b.clear_start = 1'b0;
        bus_b.wr_en = 1'b0;
        checks++; if (bus_b.busy !== 1'b1 || bus_b.fsm_state !== 1'b1) begin errors++; $display("FAIL %s_enter: got busy=%b state=%b expected 1 1", tag, bus_b.busy, bus_b.fsm_state); end
        busy_cnt = 1;
        done_cnt = 0;
        done_k = -1;
        for (int k = 1; k < 100; k++) begin
            bus_b.wr_en = with_traffic && (k == 10);
            bus_b.wr_addr = 14'd40;
            bus_b.wr_data = 9'h033;
            bus_b.clear_start = with_traffic && (k == 30);
            step();
            if (with_traffic && k == 10) begin
                checks++; if (bus_b.wr_err !== 1'b1 || bus_b.wr_done !== 1'b0) begin errors++; $display("FAIL %s_wr_during_clear: got err=%b done=%b expected err=1 done=0", tag, bus_b.wr_err, bus_b.wr_done); end
            end
            busy_cnt += int'(bus_b.busy);
            done_cnt += int'(bus_b.clear_done);
            if (bus_b.clear_done === 1'b1) done_k = k;
        end
        idle_inputs();
        checks++; if (busy_cnt !== 64) begin errors++; $display("FAIL %s_busy_cycles: got %0d expected 64", tag, busy_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL %s_done_count: got %0d expected 1", tag, done_cnt); end
        checks++; if (done_k !== 64) begin errors++; $display("FAIL %s_done_cycle: got %0d expected 64", tag, done_k); end
    endtask

    task automatic test_clear();
        idle_inputs();
        bus_b.clear_start = 1'b1;
        bus_b.wr_en = 1'b1; bus_b.wr_addr = 14'd5; bus_b.wr_data = 9'h0EE;
        @(posedge clock);
        #1;
        // the write that coincides with clear_start is still accepted
        checks++; if (bus_b.wr_done !== 1'b1 || bus_b.wr_err !== 1'b0) begin errors++; $display("FAIL clear_last_write: got done=%b err=%b expected 1 0", bus_b.wr_done, bus_b.wr_err); end
        // already at edge 0; re-enter run_clear logic from the next edge
        bus_b.clear_start = 1'b0;
        bus_b.wr_en = 1'b0;
        checks++; if (bus_b.busy !== 1'b1) begin errors++; $display("FAIL clear_busy_start: got %b expected 1", bus_b.busy); end
        begin
            int busy_cnt;
            int done_cnt;
            busy_cnt = 1;
            done_cnt = 0;
            for (int k = 1; k < 100; k++) begin
                bus_b.wr_en = (k == 10);
                bus_b.wr_addr = 14'd40;
                bus_b.wr_data = 9'h033;
                bus_b.clear_start = (k == 30);
                step();
                if (k == 10) begin
                    checks++; if (bus_b.wr_err !== 1'b1 || bus_b.wr_done !== 1'b0) begin errors++; $display("FAIL clear_wr_rejected: got err=%b done=%b expected err=1 done=0", bus_b.wr_err, bus_b.wr_done); end
                end
                if (k == 64) begin
                    checks++; if (bus_b.busy !== 1'b0 || bus_b.clear_done !== 1'b1) begin errors++; $display("FAIL clear_end_edge: got busy=%b done=%b expected 0 1", bus_b.busy, bus_b.clear_done); end
                end
                busy_cnt += int'(bus_b.busy);
                done_cnt += int'(bus_b.clear_done);
            end
            idle_inputs();
            checks++; if (busy_cnt !== 64) begin errors++; $display("FAIL clear_busy_cycles: got %0d expected 64", busy_cnt); end
            checks++; if (done_cnt !== 1) begin errors++; $display("FAIL clear_done_count: got %0d expected 1", done_cnt); end
        end
        for (int j = 0; j < 65; j++) begin
            bus_b.rd_en = (j < 64);
            bus_b.rd_addr = 14'(j);
            step();
            if (j < 64) begin
                checks++; if (bus_b.rd_valid !== 1'b1 || bus_b.rd_data !== 9'h1FF) begin errors++; $display("FAIL clear_readback[%0d]: got v=%b d=%h expected v=1 d=1ff", j, bus_b.rd_valid, bus_b.rd_data); end
            end else begin
                checks++; if (bus_b.rd_valid !== 1'b0) begin errors++; $display("FAIL clear_readback_end: got %b expected 0", bus_b.rd_valid); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_clear();
        int busy_cnt;
        int done_cnt;
        int a_valid_cnt;
        idle_inputs();
        bus_b.clear_start = 1'b1;
        step();
        bus_b.clear_start = 1'b0;
        for (int k = 1; k < 20; k++) begin
            drive_read(k == 19, 2);
            step();
        end
        idle_inputs();
        checks++; if (bus_b.rd_valid !== 1'b1 || bus_b.busy !== 1'b1) begin errors++; $display("FAIL midclr_pre: got v=%b busy=%b expected 1 1", bus_b.rd_valid, bus_b.busy); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (bus_b.busy !== 1'b0 || bus_b.fsm_state !== 1'b0) begin errors++; $display("FAIL midclr_busy: got busy=%b state=%b expected 0 0", bus_b.busy, bus_b.fsm_state); end
        checks++; if (bus_b.clear_done !== 1'b0) begin errors++; $display("FAIL midclr_done: got %b expected 0", bus_b.clear_done); end
        checks++; if (bus_b.rd_valid !== 1'b0 || bus_a.rd_valid !== 1'b0) begin errors++; $display("FAIL midclr_rd_valid: got b=%b a=%b expected 0 0", bus_b.rd_valid, bus_a.rd_valid); end
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        a_valid_cnt = 0;
        for (int k = 0; k < 80; k++) begin
            step();
            busy_cnt += int'(bus_b.busy);
            done_cnt += int'(bus_b.clear_done);
            a_valid_cnt += int'(bus_a.rd_valid);
        end
        checks++; if (done_cnt !== 0 || busy_cnt !== 0) begin errors++; $display("FAIL midclr_after: got done=%0d busy=%0d expected 0 0", done_cnt, busy_cnt); end
        checks++; if (a_valid_cnt !== 0) begin errors++; $display("FAIL midclr_pending_read: got %0d valids expected 0", a_valid_cnt); end
        bus_b.clear_start = 1'b1;
        run_clear("reclear", 1'b0);
        bus_b.rd_en = 1'b1; bus_b.rd_addr = 14'd63;
        step();
        idle_inputs();
        checks++; if (bus_b.rd_valid !== 1'b1 || bus_b.rd_data !== 9'h1FF) begin errors++; $display("FAIL reclear_read: got v=%b d=%h expected v=1 d=1ff", bus_b.rd_valid, bus_b.rd_data); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle_inputs();
        reset_n = 1'b0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_rdw();
        test_out_of_range();
        test_clear();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
